sample_queue: RTL and testbench

SAMPLE_QUEUE -- requirements
Module: sample_queue

---
 rtl/sample_queue.sv | 140 ++++++++++++++
 tb/tb_sample_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sample_queue.sv
// sample_queue: stereo sample history buffer feeding a FIR stage.
//
// Every rising edge of valid stores one {left, right} pair in a circular
// memory. Once WIN samples are held, each new sample starts a burst that
// streams the latest WIN samples, oldest first, on lft_smpl/rht_smpl while
// sequencing is high. A sample that arrives during a burst is still stored
// and schedules one trailing burst. A further sample while that trailing
// burst is already scheduled raises overrun, because its own burst is
// dropped.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   valid             codec level; a rising edge marks a new sample pair
//   lft_in, rht_in    signed sample pair, stable while valid is high
//   lft_smpl,rht_smpl streamed burst data (held when sequencing is low)
//   sequencing        high on each cycle carrying burst data
//   overrun           one-cycle pulse when a sample's burst is dropped
//
// state | meaning
// IDLE  | waiting for a qualifying sample or a scheduled trailing burst
// READ  | issuing the WIN window read addresses
// DRAIN | read pipeline emptying; the last data goes out
module sample_queue #(
  parameter int DEPTH = 1024,
  parameter int WIN   = 1021
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [15:0] lft_in,
  input  logic [15:0] rht_in,
  output logic [15:0] lft_smpl,
  output logic [15:0] rht_smpl,
  output logic        sequencing,
  output logic        overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIN + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state_q, state_d;
  logic            valid_q;
  logic [AW-1:0]   new_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fill_cnt;
  logic [CW-1:0]   fill_next;
  logic [CW-1:0]   rd_cnt;
  logic            pending;
  logic            evt;
  logic            start;
  logic            busy;
  logic [AW-1:0]   ptr_after;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     mem_q;
  logic            issue_q;

  assign evt       = valid & ~valid_q;
  assign fill_next = (fill_cnt == CW'(WIN)) ? fill_cnt : fill_cnt + 1'b1;
  assign busy      = (state_q != IDLE);
  // Write pointer as it stands once this cycle's write (if any) has landed.
  assign ptr_after = evt ? new_ptr + 1'b1 : new_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        // A scheduled trailing burst implies a full window, so an event in
        // the same cycle simply starts one burst over the newer window.
        if ((evt && fill_next == CW'(WIN)) || pending) begin
          state_d = READ;
          start   = 1'b1;
        end
      end
      READ: begin
        if (rd_cnt == CW'(WIN - 1)) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      new_ptr  <= '0;
      fill_cnt <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      rd_ptr   <= '0;
      rd_cnt   <= '0;
      issue_q  <= 1'b0;
    end else begin
      valid_q <= valid;
      overrun <= evt && busy && pending;
      if (evt) begin
        new_ptr  <= new_ptr + 1'b1;
        fill_cnt <= fill_next;
      end
      if (start)             pending <= 1'b0;
      else if (evt && busy)  pending <= 1'b1;
      if (start) begin
        rd_ptr <= ptr_after - AW'(WIN);
        rd_cnt <= '0;
      end else if (state_q == READ) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
      issue_q <= (state_q == READ);
    end
  end

  // Storage is deliberately not reset; fill_cnt keeps stale entries unread.
  always_ff @(posedge clk) begin
    if (evt) mem[new_ptr] <= {lft_in, rht_in};
    mem_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_smpl   <= '0;
      rht_smpl   <= '0;
      sequencing <= 1'b0;
    end else begin
      sequencing <= issue_q;
      if (issue_q) begin
        lft_smpl <= mem_q[31:16];
        rht_smpl <= mem_q[15:0];
      end
    end
  end

endmodule

// File: tb/tb_sample_queue.sv
module tb_sample_queue;
  localparam int DEPTH = 8;
  localparam int WIN   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] lft_in = '0;
  logic [15:0] rht_in = '0;
  logic [15:0] lft_smpl, rht_smpl;
  logic        sequencing, overrun;

  sample_queue #(.DEPTH(DEPTH), .WIN(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .lft_in(lft_in), .rht_in(rht_in),
    .lft_smpl(lft_smpl), .rht_smpl(rht_smpl), .sequencing(sequencing), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] d; } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          edge_n = 0;
  exp_t        exp_q[$];
  int          ovr_q[$];
  logic [31:0] hist[$];
  logic        m_vq;
  int          m_cnt;
  logic        m_pend;
  int          m_busy_end = -100;
  logic [15:0] last_l = '0, last_r = '0;

  // Reference model: a burst started at edge S delivers the latest WIN
  // samples on edges S+2 .. S+WIN+1; events up to edge S+WIN+1 fall inside
  // the busy period and only schedule (at most) one trailing burst.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vq = 1'b0; m_cnt = 0; m_pend = 1'b0; m_busy_end = -100;
      hist.delete(); exp_q.delete(); ovr_q.delete();
    end else begin
      logic ev;
      edge_n++;
      ev = valid && !m_vq;
      m_vq = valid;
      if (ev) begin
        hist.push_back({lft_in, rht_in});
        if (hist.size() > WIN) void'(hist.pop_front());
        if (m_cnt < WIN) m_cnt++;
      end
      if (edge_n <= m_busy_end) begin
        if (ev) begin
          if (m_pend) ovr_q.push_back(edge_n);
          m_pend = 1'b1;
        end
      end else if ((ev && m_cnt == WIN) || m_pend) begin
        m_pend = 1'b0;
        m_busy_end = edge_n + WIN + 1;
        for (int i = 0; i < WIN; i++) begin
          exp_t e;
          e.cyc = edge_n + 2 + i;
          e.d   = hist[i];
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents burst data/overrun.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_l = '0; last_r = '0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        total++; bad++;
        $display("FAIL missing_sample: expected %h at edge %0d, not seen", exp_q[0].d, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      while (ovr_q.size() > 0 && ovr_q[0] < edge_n) begin
        total++; bad++;
        $display("FAIL missing_overrun: expected pulse at edge %0d, not seen", ovr_q[0]);
        void'(ovr_q.pop_front());
      end
      if (sequencing) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_sample: got %h at edge %0d, none expected", {lft_smpl, rht_smpl}, edge_n);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != edge_n || e.d != {lft_smpl, rht_smpl}) begin
            bad++;
            $display("FAIL burst_sample: got %h at edge %0d, want %h at edge %0d",
                     {lft_smpl, rht_smpl}, edge_n, e.d, e.cyc);
          end
        end
        last_l = lft_smpl; last_r = rht_smpl;
      end else begin
        total++;
        if (lft_smpl != last_l || rht_smpl != last_r) begin
          bad++;
          $display("FAIL hold_value: got %h, want %h", {lft_smpl, rht_smpl}, {last_l, last_r});
        end
      end
      if (overrun) begin
        total++;
        if (ovr_q.size() == 0) begin
          bad++;
          $display("FAIL extra_overrun: got pulse at edge %0d, none expected", edge_n);
        end else begin
          int c;
          c = ovr_q.pop_front();
          if (c != edge_n) begin
            bad++;
            $display("FAIL overrun_time: got edge %0d, want edge %0d", edge_n, c);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r, input int hi, input int lo);
    lft_in = l; rht_in = r; valid = 1'b1;
    repeat (hi) @(negedge clk);
    valid = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    total++;
    if (sequencing !== 1'b0 || overrun !== 1'b0 || lft_smpl !== 16'h0 || rht_smpl !== 16'h0) begin
      bad++;
      $display("FAIL %s: got seq=%b ovr=%b l=%h r=%h, want all zero",
               name, sequencing, overrun, lft_smpl, rht_smpl);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 check_zero("reset_outputs");
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Warm-up then first window, then sliding windows across the pointer wrap.
    for (int n = 1; n <= 12; n++) send(16'(n), 16'(-n), 1, 12);

    // Held-high valid is one event.
    send(16'h1234, 16'hedcb, 50, 12);

    // Two events during a burst: one trailing burst plus one overrun.
    send(16'h0101, 16'hf0f0, 1, 2);
    send(16'h0202, 16'hf1f1, 1, 2);
    send(16'h0303, 16'hf2f2, 1, 20);

    // Randomised traffic with event spacing of at least three cycles.
    for (int k = 0; k < 150; k++)
      send(16'($urandom), 16'($urandom), $urandom_range(1, 4), $urandom_range(2, 6));
    repeat (20) @(negedge clk);

    // Reset on the third burst cycle.
    send(16'h7fff, 16'h8000, 1, 0);
    for (int i = 0; i < 20 && !sequencing; i++) @(negedge clk);
    total++;
    if (!sequencing) begin
      bad++;
      $display("FAIL burst_timeout: got no sequencing within 20 cycles, want a burst");
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_burst");
    @(negedge clk); #2 rst_n = 1'b1;
    for (int n = 21; n <= 25; n++) send(16'(n), 16'(-n), 1, 10);

    repeat (30) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || ovr_q.size() != 0) begin
      bad++;
      $display("FAIL drain_empty: got %0d samples and %0d overruns outstanding, want 0",
               exp_q.size(), ovr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
